// File: rtl/execute_stage.sv
// Execute stage of the 5-stage pipeline.
// Selects ALU operands from the ID/EX bundle, computes the result and
// registers it with the pass-through control into the EX/MEM bundle.
// Multiplies are computed with an iterative shift-add multiplier that
// stalls the front end through ex_busy while it runs.
//
// Ports:
//   clock, reset (synchronous, active-low)
//   ex_*   : ID/EX operand candidates, operand selects, opcode, pass-through control
//   ex_busy: combinational stall to PC/IF/ID/ID-EX (upstream holds ex_* while high)
//   mem_*  : registered EX/MEM result, store data and control
module execute_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  MUL_OP     = 4'd12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ex_shiftAmount,
  input  logic [DATA_WIDTH-1:0] ex_immediate,
  input  logic [DATA_WIDTH-1:0] ex_registerRsOrPc_4,
  input  logic [DATA_WIDTH-1:0] ex_registerRtOrZero,
  input  logic [3:0]            ex_aluOperation,
  input  logic                  ex_shouldAluUseShiftAmountElseRegisterRsOrPc_4,
  input  logic                  ex_shouldAluUseImmeidateElseRegisterRtOrZero,
  input  logic                  ex_shouldWriteRegister,
  input  logic [4:0]            ex_registerWriteAddress,
  input  logic                  ex_shouldWriteMemoryElseAluOutputToRegister,
  input  logic                  ex_shouldWriteMemory,
  output logic                  ex_busy,
  output logic [DATA_WIDTH-1:0] mem_aluOutput,
  output logic [DATA_WIDTH-1:0] mem_registerRtOrZero,
  output logic                  mem_shouldWriteRegister,
  output logic [4:0]            mem_registerWriteAddress,
  output logic                  mem_shouldWriteMemoryElseAluOutputToRegister,
  output logic                  mem_shouldWriteMemory
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);
  localparam int unsigned CNT_W   = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-1:0] multiplicand;
  logic [DATA_WIDTH-1:0] multiplier;

  logic [DATA_WIDTH-1:0] operandA;
  logic [DATA_WIDTH-1:0] operandB;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] aluResult;
  logic                  isMul;

  // Operand selection
  assign operandA = ex_shouldAluUseShiftAmountElseRegisterRsOrPc_4 ? ex_shiftAmount : ex_registerRsOrPc_4;
  assign operandB = ex_shouldAluUseImmeidateElseRegisterRtOrZero ? ex_immediate : ex_registerRtOrZero;
  assign shamt    = operandA[SHAMT_W-1:0];
  assign isMul    = (ex_aluOperation == MUL_OP);

  // Stall held through IDLE and all BUSY cycles; released in DONE so upstream advances
  assign ex_busy = reset && isMul && (state != DONE);

  // Single-cycle ALU; MUL and unused codes produce 0 here
  always_comb begin
    aluResult = '0;
    case (ex_aluOperation)
      4'd0:  aluResult = operandA + operandB;
      4'd1:  aluResult = operandA - operandB;
      4'd2:  aluResult = operandA & operandB;
      4'd3:  aluResult = operandA | operandB;
      4'd4:  aluResult = operandA ^ operandB;
      4'd5:  aluResult = ~(operandA | operandB);
      4'd6:  aluResult = DATA_WIDTH'($signed(operandA) < $signed(operandB));
      4'd7:  aluResult = DATA_WIDTH'(operandA < operandB);
      4'd8:  aluResult = operandB << shamt;
      4'd9:  aluResult = operandB >> shamt;
      4'd10: aluResult = DATA_WIDTH'($signed(operandB) >>> shamt);
      4'd11: aluResult = operandB << 16;
      default: aluResult = '0;
    endcase
  end

  // Control FSM, multiplier datapath and EX/MEM register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state                                        <= IDLE;
      count                                        <= '0;
      product                                      <= '0;
      multiplicand                                 <= '0;
      multiplier                                   <= '0;
      mem_aluOutput                                <= '0;
      mem_registerRtOrZero                         <= '0;
      mem_shouldWriteRegister                      <= 1'b0;
      mem_registerWriteAddress                     <= '0;
      mem_shouldWriteMemoryElseAluOutputToRegister <= 1'b0;
      mem_shouldWriteMemory                        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (isMul) begin
            multiplicand                                 <= operandA;
            multiplier                                   <= operandB;
            product                                      <= '0;
            count                                        <= '0;
            state                                        <= BUSY;
            // Bubble: control cleared, data left as is
            mem_shouldWriteRegister                      <= 1'b0;
            mem_registerWriteAddress                     <= '0;
            mem_shouldWriteMemoryElseAluOutputToRegister <= 1'b0;
            mem_shouldWriteMemory                        <= 1'b0;
          end else begin
            mem_aluOutput                                <= aluResult;
            mem_registerRtOrZero                         <= ex_registerRtOrZero;
            mem_shouldWriteRegister                      <= ex_shouldWriteRegister;
            mem_registerWriteAddress                     <= ex_registerWriteAddress;
            mem_shouldWriteMemoryElseAluOutputToRegister <= ex_shouldWriteMemoryElseAluOutputToRegister;
            mem_shouldWriteMemory                        <= ex_shouldWriteMemory;
          end
        end
        BUSY: begin
          if (multiplier[0]) product <= product + multiplicand;
          multiplicand                                 <= multiplicand << 1;
          multiplier                                   <= multiplier >> 1;
          count                                        <= count + CNT_W'(1);
          if (count == CNT_W'(DATA_WIDTH - 1)) state <= DONE;
          mem_shouldWriteRegister                      <= 1'b0;
          mem_registerWriteAddress                     <= '0;
          mem_shouldWriteMemoryElseAluOutputToRegister <= 1'b0;
          mem_shouldWriteMemory                        <= 1'b0;
        end
        DONE: begin
          // Pass-throughs come from the inputs upstream is still holding
          mem_aluOutput                                <= product;
          mem_registerRtOrZero                         <= ex_registerRtOrZero;
          mem_shouldWriteRegister                      <= ex_shouldWriteRegister;
          mem_registerWriteAddress                     <= ex_registerWriteAddress;
          mem_shouldWriteMemoryElseAluOutputToRegister <= ex_shouldWriteMemoryElseAluOutputToRegister;
          mem_shouldWriteMemory                        <= ex_shouldWriteMemory;
          state                                        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage pipeline. Consumes the registered ID/EX control and data bundle, selects the ALU operands and computes the result.
- Single-cycle ops complete in one cycle. MUL runs on an iterative 32-step shift-add multiplier and stalls the front end while it works.
- Result and pass-through control are registered into the EX/MEM bundle for the memory stage.

Parameters:
- DATA_WIDTH, 32, datapath width; the multiplier iteration count equals DATA_WIDTH.
- MUL_OP, 4'd12, aluOperation code that selects the iterative multiply.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- ex_shiftAmount  input  32  operand A candidate
- ex_immediate  input  32  operand B candidate
- ex_registerRsOrPc_4  input  32  operand A candidate
- ex_registerRtOrZero  input  32  operand B candidate; also store data
- ex_aluOperation  input  4  operation code
- ex_shouldAluUseShiftAmountElseRegisterRsOrPc_4  input  1  A select
- ex_shouldAluUseImmeidateElseRegisterRtOrZero  input  1  B select
- ex_shouldWriteRegister  input  1  pass-through
- ex_registerWriteAddress  input  5  pass-through
- ex_shouldWriteMemoryElseAluOutputToRegister  input  1  pass-through
- ex_shouldWriteMemory  input  1  pass-through
- ex_busy  output  1  combinational stall to PC/IF/ID/ID-EX; upstream holds all ex_* inputs while high
- mem_aluOutput  output  32  registered result
- mem_registerRtOrZero  output  32  registered store data
- mem_shouldWriteRegister  output  1  registered
- mem_registerWriteAddress  output  5  registered
- mem_shouldWriteMemoryElseAluOutputToRegister  output  1  registered
- mem_shouldWriteMemory  output  1  registered

Behaviour:
- Operand A = select ? ex_shiftAmount : ex_registerRsOrPc_4. Operand B = select ? ex_immediate : ex_registerRtOrZero.
- Opcodes (all arithmetic mod 2^32, no overflow trap):
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed A<B gives 1, else 0), 7 SLTU (unsigned)
  - 8 SLL (B<<A[4:0]), 9 SRL (B>>A[4:0] logical), 10 SRA (B>>>A[4:0])
  - 11 LUI (B<<16), 12 MUL (low 32 bits of A*B)
  - 13-15 give result 0
- FSM states:
  - IDLE: if op!=MUL, register result plus pass-throughs into mem_* at the next edge (1-cycle latency). If op==MUL: latch A into multiplicand, B into multiplier, clear product and count, go to BUSY, and write a bubble (all four mem_* control bits 0, data unchanged).
  - BUSY: each cycle, if multiplier[0] then product += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++. After 32 iterations (count==31 step) go to DONE. Bubble written each cycle.
  - DONE: mem_aluOutput <= product, pass-throughs registered from the held inputs, go to IDLE.
- ex_busy = reset && (op==MUL) && state!=DONE. For one MUL it is high for exactly 33 cycles (the IDLE cycle plus 32 BUSY cycles) and low in the DONE cycle, so upstream advances on that edge.
- MUL total latency: presented in cycle N, result in mem_* after the edge ending cycle N+33.
- Back-to-back MUL: DONE returns to IDLE, and the next MUL restarts normally. No result is carried between multiplies.
- Reset low (sampled at the edge): state IDLE, count 0, product/multiplicand/multiplier 0, all mem_* outputs 0. ex_busy is 0 while reset is low. A MUL in flight is abandoned. If a MUL is still held on the inputs after reset releases, it restarts from IDLE.
- Inputs are not sampled by the datapath during BUSY; only the latched operands are used. Pass-throughs are taken from the inputs in the DONE cycle, which upstream holds stable.

Test Plan:
- ADD, A=RsOrPc_4=5, B=RtOrZero=7, selects 0, shouldWriteRegister=1, addr=3 -> next edge mem_aluOutput=12, mem_registerWriteAddress=3, ex_busy stays 0.
- SRA with A from shiftAmount=4, B=0xF0000000 -> 0xFF000000. SRL on the same operands -> 0x0F000000. SLT(0xFFFFFFFF, 1) -> 1. SLTU on the same operands -> 0.
- MUL 0x00010003 * 0x00000007 -> ex_busy high exactly 33 cycles, mem control bits 0 throughout, then mem_aluOutput=0x00070015 with the pass-throughs applied.
- MUL 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000001. Immediately followed by ADD 1+1 -> 2 one cycle after the MUL result, with no extra stall.
- Reset low at BUSY count 10 -> all mem_* become 0 and ex_busy drops at once. After release with MUL 3*4 still held -> a fresh 33-cycle busy window and result 12.
- Store path: ex_shouldWriteMemory=1, RtOrZero=0xDEADBEEF, ADD base 0x100 + imm 8 -> mem_aluOutput=0x108, mem_registerRtOrZero=0xDEADBEEF, mem_shouldWriteMemory=1.
